// File: rtl/fetch_unit_if.sv
// +--------------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory request/response bus                  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------------+
// | fetch_unit : PC register, branch/next-PC datapath and timed imem fetch   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_unit (
  input  logic                clk,
  input  logic                rst_f,
  input  logic                ir_load,
  input  logic                pc_write,
  input  logic                pc_sel,
  input  logic                br_sel,
  input  logic                pc_rst,
  fetch_unit_if.master        imem,
  output logic [31:0]         ir,
  output logic [3:0]          opcode,
  output logic [3:0]          mm,
  output logic [15:0]         pc_out,
  output logic                fetch_busy,
  output logic                fetch_done,
  output logic                fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [15:0] br_addr;
  logic [15:0] pc_in;
  logic        start_fetch;
  logic        capture;
  logic        timeout;

  assign opcode  = ir[31:28];
  assign mm      = ir[27:24];
  assign br_addr = br_sel ? ir[15:0] : (pc_out + ir[15:0]);
  assign pc_in   = pc_sel ? br_addr : (pc_out + 16'd1);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    fetch_busy    = 1'b0;
    fetch_done    = 1'b0;
    start_fetch   = 1'b0;
    capture       = 1'b0;
    timeout       = 1'b0;
    case (state)
      S_IDLE: begin
        if (ir_load) begin
          start_fetch = 1'b1;
          state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        imem.imem_req = 1'b1;
        fetch_busy    = 1'b1;
        // an ack arriving on the last allowed cycle still delivers data
        if (imem.imem_ack) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end else if (wait_cnt == 4'd15) begin
          timeout   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        fetch_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      imem.imem_addr <= 16'd0;
      wait_cnt       <= 4'd0;
      ir             <= 32'd0;
      fetch_err      <= 1'b0;
      pc_out         <= 16'd0;
    end else begin
      if (start_fetch) begin
        imem.imem_addr <= pc_out;
        wait_cnt       <= 4'd0;
      end else if ((state == S_REQ) && !imem.imem_ack) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      // a timed-out fetch leaves a NOOP in the instruction register
      if (capture) begin
        ir <= imem.imem_rdata;
      end else if (timeout) begin
        ir <= 32'd0;
      end

      if (pc_rst) begin
        fetch_err <= 1'b0;
      end else if (timeout) begin
        fetch_err <= 1'b1;
      end

      if (pc_rst) begin
        pc_out <= 16'd0;
      end else if (pc_write) begin
        pc_out <= pc_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed scenarios plus random traffic vs. a fetch model |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        ir_load;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        pc_rst;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc_out;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .pc_rst     (pc_rst),
    .imem       (bus.master),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .pc_out     (pc_out),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is either absent, in flight for m_wait cycles,
  // or just completed; the PC is plain modulo-65536 integer arithmetic.
  int          m_pc      = 0;
  logic [31:0] m_ir      = 32'd0;
  bit          m_err     = 1'b0;
  bit          m_fetching = 1'b0;
  bit          m_done    = 1'b0;
  int          m_wait    = 0;
  int          m_addr    = 0;

  function automatic int branch_target(input int pc, input logic [31:0] cur_ir, input logic bsel);
    return bsel ? int'(cur_ir[15:0]) : (pc + int'(cur_ir[15:0])) % 65536;
  endfunction

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      m_pc       <= 0;
      m_ir       <= 32'd0;
      m_err      <= 1'b0;
      m_fetching <= 1'b0;
      m_done     <= 1'b0;
      m_wait     <= 0;
      m_addr     <= 0;
    end else begin
      if (pc_rst)        m_pc <= 0;
      else if (pc_write) m_pc <= pc_sel ? branch_target(m_pc, m_ir, br_sel) : (m_pc + 1) % 65536;

      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_fetching) begin
        if (bus.imem_ack) begin
          m_ir       <= bus.imem_rdata;
          m_fetching <= 1'b0;
          m_done     <= 1'b1;
        end else if (m_wait == 15) begin
          m_ir       <= 32'd0;
          m_fetching <= 1'b0;
          m_done     <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (ir_load) begin
        m_fetching <= 1'b1;
        m_addr     <= m_pc;
        m_wait     <= 0;
      end

      if (pc_rst)
        m_err <= 1'b0;
      else if (m_fetching && !m_done && !bus.imem_ack && m_wait == 15)
        m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_req",   32'(bus.imem_req), 32'(m_fetching));
      check("fetch_busy", 32'(fetch_busy),   32'(m_fetching));
      check("fetch_done", 32'(fetch_done),   32'(m_done));
      check("imem_addr",  32'(bus.imem_addr), 32'(m_addr));
      check("ir",         ir,                m_ir);
      check("opcode",     32'(opcode),       32'(m_ir[31:28]));
      check("mm",         32'(mm),           32'(m_ir[27:24]));
      check("pc_out",     32'(pc_out),       32'(m_pc));
      check("fetch_err",  32'(fetch_err),    32'(m_err));
    end
  end

  // Inputs change 2 time units after the falling edge, clear of both edges.
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic do_fetch(input logic [31:0] data);
    ir_load = 1'b1;
    cyc();
    ir_load        = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    cyc();
    bus.imem_ack = 1'b0;
    cyc();
  endtask

  int req_cycles;
  bit done_seen;

  initial begin
    rst_f          = 1'b0;
    ir_load        = 1'b0;
    pc_write       = 1'b0;
    pc_sel         = 1'b0;
    br_sel         = 1'b0;
    pc_rst         = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    cyc();
    cmp_en = 1'b1;
    cyc();

    check("rst_ir",        ir, 32'd0);
    check("rst_pc",        32'(pc_out), 32'd0);
    check("rst_imem_req",  32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_done",      32'(fetch_done), 32'd0);
    check("rst_err",       32'(fetch_err), 32'd0);
    rst_f = 1'b1;
    cyc();

    // Minimal-latency fetch right after reset
    ir_load = 1'b1;
    cyc();
    check("first_req",  32'(bus.imem_req), 32'd1);
    check("first_addr", 32'(bus.imem_addr), 32'h0000);
    ir_load        = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h8123_0004;
    cyc();
    bus.imem_ack = 1'b0;
    check("first_ir",     ir, 32'h8123_0004);
    check("first_opcode", 32'(opcode), 32'd8);
    check("first_mm",     32'(mm), 32'd1);
    check("first_done",   32'(fetch_done), 32'd1);
    cyc();
    check("first_done_drop", 32'(fetch_done), 32'd0);

    // Branch arithmetic and PC wrap
    pc_write = 1'b1;
    pc_sel   = 1'b0;
    repeat (16) cyc();
    pc_write = 1'b0;
    check("pc_0010", 32'(pc_out), 32'h0010);
    do_fetch(32'h0000_FFFE);
    pc_sel   = 1'b1;
    br_sel   = 1'b0;
    pc_write = 1'b1;
    cyc();
    check("br_rel", 32'(pc_out), 32'h000E);
    br_sel = 1'b1;
    cyc();
    check("br_abs", 32'(pc_out), 32'hFFFE);
    pc_sel = 1'b0;
    cyc();
    check("pc_ffff", 32'(pc_out), 32'hFFFF);
    cyc();
    check("pc_wrap", 32'(pc_out), 32'h0000);
    pc_write = 1'b0;
    br_sel   = 1'b0;

    // Timeout: request held for exactly 16 cycles
    ir_load = 1'b1;
    cyc();
    ir_load    = 1'b0;
    req_cycles = 0;
    done_seen  = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (bus.imem_req) req_cycles++;
      if (fetch_done) done_seen = 1'b1;
      else cyc();
    end
    check("to_done_seen",  32'(done_seen), 32'd1);
    check("to_req_cycles", 32'(req_cycles), 32'd16);
    check("to_ir",         ir, 32'd0);
    check("to_opcode",     32'(opcode), 32'd0);
    check("to_err",        32'(fetch_err), 32'd1);
    repeat (3) cyc();
    check("to_err_held", 32'(fetch_err), 32'd1);
    pc_rst = 1'b1;
    cyc();
    pc_rst = 1'b0;
    check("pcrst_err", 32'(fetch_err), 32'd0);
    check("pcrst_pc",  32'(pc_out), 32'd0);

    // Ack on the 16th REQ cycle wins over timeout
    ir_load = 1'b1;
    cyc();
    ir_load = 1'b0;
    repeat (15) cyc();
    check("late_req", 32'(bus.imem_req), 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hF000_0000;
    cyc();
    bus.imem_ack = 1'b0;
    check("late_ir",   ir, 32'hF000_0000);
    check("late_done", 32'(fetch_done), 32'd1);
    check("late_err",  32'(fetch_err), 32'd0);
    cyc();

    // ir_load held through REQ/DONE, PC rewritten mid-fetch
    do_fetch(32'h1000_0005);
    pc_write = 1'b1;
    pc_sel   = 1'b0;
    repeat (3) cyc();
    pc_write = 1'b0;
    ir_load  = 1'b1;
    cyc();
    pc_write = 1'b1;
    pc_sel   = 1'b1;
    br_sel   = 1'b1;
    cyc();
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    cyc();
    check("mid_pc",   32'(pc_out), 32'h0005);
    check("mid_addr", 32'(bus.imem_addr), 32'h0003);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h2000_0000;
    cyc();
    bus.imem_ack = 1'b0;
    check("mid_done", 32'(fetch_done), 32'd1);
    cyc();
    check("mid_no_requeue", 32'(bus.imem_req), 32'd0);
    ir_load = 1'b0;
    cyc();

    // Reset in the middle of a fetch, then a stray ack
    ir_load = 1'b1;
    cyc();
    ir_load = 1'b0;
    cyc();
    cyc();
    rst_f = 1'b0;
    #1;
    check("arst_req",  32'(bus.imem_req), 32'd0);
    check("arst_busy", 32'(fetch_busy), 32'd0);
    check("arst_ir",   ir, 32'd0);
    check("arst_pc",   32'(pc_out), 32'd0);
    cyc();
    rst_f          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    bus.imem_ack = 1'b0;
    check("stray_ir",   ir, 32'd0);
    check("stray_done", 32'(fetch_done), 32'd0);
    check("stray_req",  32'(bus.imem_req), 32'd0);

    // Random traffic; second half has rare acks so timeouts occur
    for (int i = 0; i < 4000; i++) begin
      rst_f          = ($urandom_range(0, 299) != 0);
      ir_load        = ($urandom_range(0, 2) == 0);
      pc_write       = ($urandom_range(0, 2) == 0);
      pc_sel         = 1'($urandom_range(0, 1));
      br_sel         = 1'($urandom_range(0, 1));
      pc_rst         = ($urandom_range(0, 19) == 0);
      bus.imem_ack   = (i < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      bus.imem_rdata = $urandom;
      cyc();
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
